// File: rtl/ir_nec_rx_pkg.sv
// Shared constants, FSM states and frame layout for the NEC IR receiver.
// NEC_EXT_ADDR_EN: when defined, only the cmd/cmd_n pair is validated (16-bit address).
package ir_nec_pkg;
  localparam int unsigned IVAL_W = 11;

  // Pulse windows, in 10 us ticks
  localparam logic [IVAL_W-1:0] LEAD_MARK_MIN  = 11'd800;
  localparam logic [IVAL_W-1:0] LEAD_MARK_MAX  = 11'd1000;
  localparam logic [IVAL_W-1:0] LEAD_SPACE_MIN = 11'd400;
  localparam logic [IVAL_W-1:0] LEAD_SPACE_MAX = 11'd500;
  localparam logic [IVAL_W-1:0] REP_SPACE_MIN  = 11'd200;
  localparam logic [IVAL_W-1:0] REP_SPACE_MAX  = 11'd250;
  localparam logic [IVAL_W-1:0] BIT_MARK_MIN   = 11'd40;
  localparam logic [IVAL_W-1:0] BIT_MARK_MAX   = 11'd70;
  localparam logic [IVAL_W-1:0] ZERO_MIN       = 11'd40;
  localparam logic [IVAL_W-1:0] ZERO_MAX       = 11'd70;
  localparam logic [IVAL_W-1:0] ONE_MIN        = 11'd140;
  localparam logic [IVAL_W-1:0] ONE_MAX        = 11'd190;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEAD_MARK, ST_LEAD_SPACE, ST_BIT_MARK, ST_BIT_SPACE
  } nec_state_e;

  typedef struct packed {
    logic [7:0] cmd_n;
    logic [7:0] cmd;
    logic [7:0] addr_n;
    logic [7:0] addr;
  } nec_frame_t;

  function automatic logic in_win(logic [IVAL_W-1:0] v, logic [IVAL_W-1:0] lo,
                                  logic [IVAL_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic frame_ok(nec_frame_t f);
`ifdef NEC_EXT_ADDR_EN
    return (f.cmd ^ f.cmd_n) == 8'hFF;
`else
    return ((f.addr ^ f.addr_n) == 8'hFF) && ((f.cmd ^ f.cmd_n) == 8'hFF);
`endif
  endfunction
endpackage

// File: rtl/ir_nec_rx_if.sv
// APB3 slave-side signal bundle for the NEC IR receiver.
interface ir_nec_rx_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PREADY, PSLVERR, PRDATA);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PREADY, PSLVERR, PRDATA);
endinterface

// File: rtl/ir_nec_rx_fifo.sv
// Frame FIFO; a pop frees a slot for a same-cycle push when full.
module ir_frame_fifo
  import ir_nec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  nec_frame_t             din,
  output nec_frame_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  nec_frame_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame decoder with APB3 register file and frame FIFO.
// NEC_EXT_ADDR_EN selects extended-address frame validation (see ir_nec_pkg).
module ir_nec_rx
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_TICKS  = 1100
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  ir_nec_rx_if.slave  apb,
  input  logic        ir_in,
  output logic        irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic ir_s1, ir_s2, ir_d, fall, rise;
  logic [PW-1:0] pcnt;
  logic tick, tmo;
  logic [IVAL_W-1:0] ival;
  nec_state_e state, state_n;
  logic [5:0]  bcnt, bcnt_n;
  logic [31:0] sh, sh_n;
  logic done, done_n, push;
  logic [1:0] ctrl;
  logic ovf;
  logic rd_acc, wr_acc, pop;
  nec_frame_t fifo_dout;
  logic full, empty;
  logic [CW-1:0] count;
  logic unused_bits;

  assign fall = ir_d & ~ir_s2;
  assign rise = ~ir_d & ir_s2;
  assign tick = (pcnt == PW'(TICK_DIV - 1));
  assign tmo  = (ival == IVAL_W'(TMO_TICKS));

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      {ir_s1, ir_s2, ir_d} <= 3'b111;
      pcnt <= '0;
      ival <= '0;
    end else begin
      {ir_s1, ir_s2, ir_d} <= {ir_in, ir_s1, ir_s2};
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (fall | rise)       ival <= '0;
      else if (tick && !tmo) ival <= ival + IVAL_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state <= ST_IDLE;
      bcnt  <= '0;
      sh    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      sh    <= sh_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sh_n    = sh;
    done_n  = 1'b0;
    if (!ctrl[0]) state_n = ST_IDLE;
    else if (state != ST_IDLE && tmo) state_n = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:      if (fall) state_n = ST_LEAD_MARK;
        ST_LEAD_MARK: if (rise)
          state_n = in_win(ival, LEAD_MARK_MIN, LEAD_MARK_MAX) ? ST_LEAD_SPACE : ST_IDLE;
        ST_LEAD_SPACE: if (fall) begin
          if (in_win(ival, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            state_n = ST_BIT_MARK;
            bcnt_n  = '0;
          end else if (in_win(ival, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            state_n = ST_IDLE;  // repeat code carries no new frame
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_BIT_MARK: if (rise)
          state_n = in_win(ival, BIT_MARK_MIN, BIT_MARK_MAX) ? ST_BIT_SPACE : ST_IDLE;
        ST_BIT_SPACE: if (fall) begin
          if (in_win(ival, ZERO_MIN, ZERO_MAX) || in_win(ival, ONE_MIN, ONE_MAX)) begin
            sh_n    = {in_win(ival, ONE_MIN, ONE_MAX), sh[31:1]};
            bcnt_n  = bcnt + 6'd1;
            done_n  = (bcnt == 6'd31);
            state_n = (bcnt == 6'd31) ? ST_IDLE : ST_BIT_MARK;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Frame check happens the cycle after the last bit is shifted in
  assign push = done & frame_ok(nec_frame_t'(sh));

  ir_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(PCLK), .rst_n(PRESERN), .push(push), .pop(pop), .din(nec_frame_t'(sh)),
    .dout(fifo_dout), .full(full), .empty(empty), .count(count)
  );

  assign rd_acc = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign wr_acc = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign pop    = rd_acc & (apb.PADDR[3:2] == REG_DATA);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl <= '0;
      ovf  <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wr_acc && apb.PADDR[3:2] == REG_CTRL) ctrl <= apb.PWDATA[1:0];
      if (push && full && !pop) ovf <= 1'b1;
      else if (wr_acc && apb.PADDR[3:2] == REG_STATUS && apb.PWDATA[2]) ovf <= 1'b0;
      irq <= ctrl[1] & ~empty;
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL) begin
      case (apb.PADDR[3:2])
        REG_STATUS: apb.PRDATA = {24'd0, 4'(count), 1'b0, ovf, full, ~empty};
        REG_DATA:   if (!empty) apb.PRDATA = fifo_dout;
        REG_CTRL:   apb.PRDATA = {30'd0, ctrl};
        REG_RSVD:   apb.PRDATA = '0;
        default:    apb.PRDATA = '0;
      endcase
    end
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign unused_bits = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA[31:3]};
endmodule
